// File: rtl/aukv_mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-bus signals around the AUK-V memory arbiter.
// The master modport is the arbiter's view; the slave modport is the core/memory side.
interface aukv_mem_arbiter_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;

   logic          i_if_req;
   logic [AW-1:0] i_if_addr;
   logic          i_if_flush;
   logic          o_if_ack;
   logic [DW-1:0] o_if_data;
   logic          o_if_valid;

   logic          i_d_req;
   logic          i_d_we;
   logic [AW-1:0] i_d_addr;
   logic [DW-1:0] i_d_wdata;
   logic [BW-1:0] i_d_be;
   logic          o_d_ack;
   logic [DW-1:0] o_d_rdata;
   logic          o_d_valid;

   logic          o_mem_req;
   logic          o_mem_we;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic [BW-1:0] o_mem_be;
   logic          i_mem_gnt;
   logic          i_mem_rvalid;
   logic [DW-1:0] i_mem_rdata;

   modport master (
      input  i_if_req, i_if_addr, i_if_flush,
      output o_if_ack, o_if_data, o_if_valid,
      input  i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
      output o_d_ack, o_d_rdata, o_d_valid,
      output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
      input  i_mem_gnt, i_mem_rvalid, i_mem_rdata
   );

   modport slave (
      output i_if_req, i_if_addr, i_if_flush,
      input  o_if_ack, o_if_data, o_if_valid,
      output i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
      input  o_d_ack, o_d_rdata, o_d_valid,
      input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
      output i_mem_gnt, i_mem_rvalid, i_mem_rdata
   );
endinterface

// File: rtl/aukv_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and load/store.
// Optional fetch anti-starvation counter enabled by defining AUKV_ARB_FAIRNESS_EN.
module aukv_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic                 i_clk,
   input logic                 i_rst,
   aukv_mem_arbiter_if.master  bus
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = 4;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("aukv_mem_arbiter: STARVE_LIMIT must be within 1..15");
   end

   typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D} state_e;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [BW-1:0] be;
   } mem_req_t;

   state_e   state_q, state_d;
   mem_req_t req_q, req_d;
   logic     stale_q, stale_d;
   logic     grant_d_c, grant_i_c;
   logic     fetch_first_c;
   logic     rsp_i_c, rsp_d_c, mem_req_c;

`ifdef AUKV_ARB_FAIRNESS_EN
   localparam int unsigned CW = 4;
   logic [CW-1:0] starve_q, starve_d;

   // Fetch overrides data priority once it has lost STARVE_LIMIT times in a row.
   assign fetch_first_c = bus.i_if_req && (starve_q == CW'(STARVE_LIMIT));

   always_comb begin
      starve_d = starve_q;
      if (state_q == IDLE) begin
         if (grant_i_c || !bus.i_if_req) starve_d = '0;
         else if (grant_d_c)             starve_d = starve_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) starve_q <= '0;
      else       starve_q <= starve_d;
   end
`else
   assign fetch_first_c = 1'b0;
`endif

   // Next-state, request latching and stale tracking.
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      stale_d   = stale_q;
      grant_d_c = 1'b0;
      grant_i_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            stale_d = 1'b0;
            if (bus.i_d_req && !fetch_first_c) begin
               grant_d_c = 1'b1;
               req_d     = '{we: bus.i_d_we, addr: bus.i_d_addr,
                             wdata: bus.i_d_wdata, be: bus.i_d_be};
               state_d   = REQ_D;
            end else if (bus.i_if_req) begin
               grant_i_c = 1'b1;
               req_d     = '{we: 1'b0, addr: bus.i_if_addr,
                             wdata: '0, be: '1};
               state_d   = REQ_I;
            end
         end
         REQ_I: begin
            if (bus.i_if_flush) stale_d = 1'b1;
            if (bus.i_mem_gnt)  state_d = WAIT_I;
         end
         REQ_D: begin
            if (bus.i_mem_gnt) state_d = WAIT_D;
         end
         WAIT_I: begin
            if (bus.i_mem_rvalid) begin
               state_d = IDLE;
               stale_d = 1'b0;
            end else if (bus.i_if_flush) begin
               stale_d = 1'b1;
            end
         end
         WAIT_D: begin
            if (bus.i_mem_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         req_q   <= '0;
         stale_q <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         stale_q <= stale_d;
      end
   end

   // Responses pass straight through in the cycle the memory completes.
   assign rsp_i_c = (state_q == WAIT_I) && bus.i_mem_rvalid && !i_rst;
   assign rsp_d_c = (state_q == WAIT_D) && bus.i_mem_rvalid && !i_rst;
   assign mem_req_c = (state_q == REQ_I) || (state_q == REQ_D);

   assign bus.o_if_ack   = grant_i_c && !i_rst;
   assign bus.o_d_ack    = grant_d_c && !i_rst;
   assign bus.o_if_valid = rsp_i_c && !stale_q && !bus.i_if_flush;
   assign bus.o_if_data  = rsp_i_c ? bus.i_mem_rdata : '0;
   assign bus.o_d_valid  = rsp_d_c;
   assign bus.o_d_rdata  = (rsp_d_c && !req_q.we) ? bus.i_mem_rdata : '0;

   assign bus.o_mem_req   = mem_req_c;
   assign bus.o_mem_we    = mem_req_c && req_q.we;
   assign bus.o_mem_addr  = mem_req_c ? req_q.addr  : '0;
   assign bus.o_mem_wdata = mem_req_c ? req_q.wdata : '0;
   assign bus.o_mem_be    = mem_req_c ? req_q.be    : '0;
endmodule

// File: tb/tb_aukv_mem_arbiter.sv
// Self-checking bench for aukv_mem_arbiter: directed scenarios then randomized transactions
// checked against a transaction-level model of grant order, bus fields and responses.
module tb_aukv_mem_arbiter;
`ifdef AUKV_ARB_FAIRNESS_EN
   localparam int unsigned LIMIT = 2;
   localparam bit          FAIR  = 1'b1;
`else
   localparam int unsigned LIMIT = 4;
   localparam bit          FAIR  = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aukv_mem_arbiter_if bus();
   aukv_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   int checks = 0;
   int passed = 0;

   // Pending requests as seen by the requesters, plus model fairness history.
   logic        d_pend = 1'b0, d_we = 1'b0;
   logic [31:0] d_addr = '0, d_wdata = '0;
   logic [3:0]  d_be = '0;
   logic        if_pend = 1'b0;
   logic [31:0] if_addr = '0;
   int          starve = 0;
   int          dut_win = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %b expected %b", tag, obs, exp);
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic set_in(input logic gnt, input logic rv, input logic [31:0] rd, input logic fl);
      bus.i_d_req      = d_pend;
      bus.i_d_we       = d_we;
      bus.i_d_addr     = d_addr;
      bus.i_d_wdata    = d_wdata;
      bus.i_d_be       = d_be;
      bus.i_if_req     = if_pend;
      bus.i_if_addr    = if_addr;
      bus.i_if_flush   = fl;
      bus.i_mem_gnt    = gnt;
      bus.i_mem_rvalid = rv;
      bus.i_mem_rdata  = rd;
   endtask

   task automatic new_d();
      d_pend  = 1'b1;
      d_we    = 1'($urandom_range(0, 1));
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_be    = 4'($urandom);
   endtask

   // One arbitration cycle plus (if granted) the full memory transaction.
   // flush_cyc indexes the non-idle cycles: 0..gnt_dly are request cycles, then wait cycles.
   task automatic run_txn(input int gnt_dly, input int rv_wait, input int flush_cyc,
                          input logic [31:0] rdata);
      int          win;
      logic        stale, fl, e_we;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_be;
      stale = 1'b0;
      if (d_pend && !(FAIR && if_pend && starve == int'(LIMIT))) win = 1;
      else if (if_pend)                                            win = 2;
      else                                                         win = 0;

      @(negedge clk);
      set_in(1'b0, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0));
      #1;
      dut_win = bus.o_d_ack ? 1 : (bus.o_if_ack ? 2 : 0);
      chk1("d_ack", bus.o_d_ack, win == 1);
      chk1("if_ack", bus.o_if_ack, win == 2);
      chk1("idle_mem_req", bus.o_mem_req, 1'b0);
      chk1("idle_d_valid", bus.o_d_valid, 1'b0);
      chk1("idle_if_valid", bus.o_if_valid, 1'b0);

      e_we = 1'b0; e_addr = '0; e_wdata = '0; e_be = '0;
      if (win == 1) begin
         e_we = d_we; e_addr = d_addr; e_wdata = d_wdata; e_be = d_be;
         starve = if_pend ? starve + 1 : 0;
         d_pend = 1'b0;
      end else if (win == 2) begin
         e_addr = if_addr; e_be = 4'hF;
         starve = 0;
         if_pend = 1'b0;
      end else begin
         starve = 0;
      end

      if (win != 0) begin
         for (int k = 0; k <= gnt_dly; k++) begin
            @(negedge clk);
            fl = (flush_cyc == k);
            set_in(k == gnt_dly, (k != gnt_dly) ? 1'($urandom_range(0, 1)) : 1'b0, $urandom, fl);
            if (win == 2 && fl) stale = 1'b1;
            #1;
            chk1("mem_req", bus.o_mem_req, 1'b1);
            chk1("mem_we", bus.o_mem_we, e_we);
            chk32("mem_addr", bus.o_mem_addr, e_addr);
            chk32("mem_wdata", bus.o_mem_wdata, e_wdata);
            chk32("mem_be", 32'(bus.o_mem_be), 32'(e_be));
            chk1("busy_d_ack", bus.o_d_ack, 1'b0);
            chk1("busy_if_ack", bus.o_if_ack, 1'b0);
            chk1("req_d_valid", bus.o_d_valid, 1'b0);
            chk1("req_if_valid", bus.o_if_valid, 1'b0);
         end
         for (int k = 0; k <= rv_wait; k++) begin
            @(negedge clk);
            fl = (flush_cyc == gnt_dly + 1 + k);
            set_in(1'b0, k == rv_wait, (k == rv_wait) ? rdata : $urandom, fl);
            if (win == 2 && fl) stale = 1'b1;
            #1;
            chk1("wait_mem_req", bus.o_mem_req, 1'b0);
            chk1("wait_d_ack", bus.o_d_ack, 1'b0);
            chk1("wait_if_ack", bus.o_if_ack, 1'b0);
            if (k == rv_wait) begin
               chk1("if_valid", bus.o_if_valid, (win == 2) && !stale);
               chk1("d_valid", bus.o_d_valid, win == 1);
               if (win == 2 && !stale) chk32("if_data", bus.o_if_data, rdata);
               if (win == 1) chk32("d_rdata", bus.o_d_rdata, e_we ? 32'h0 : rdata);
            end else begin
               chk1("early_if_valid", bus.o_if_valid, 1'b0);
               chk1("early_d_valid", bus.o_d_valid, 1'b0);
            end
         end
      end
   endtask

   initial begin
      int exp_order [6];
      exp_order = '{1, 1, 2, 1, 1, 2};

      // Reset state
      set_in(1'b0, 1'b0, '0, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk1("rst_mem_req", bus.o_mem_req, 1'b0);
      chk32("rst_mem_addr", bus.o_mem_addr, 32'h0);
      chk1("rst_d_ack", bus.o_d_ack, 1'b0);
      chk1("rst_if_ack", bus.o_if_ack, 1'b0);
      chk1("rst_d_valid", bus.o_d_valid, 1'b0);
      chk1("rst_if_valid", bus.o_if_valid, 1'b0);

      // Single fetch at minimum latency
      if_pend = 1'b1; if_addr = 32'h8000_0000;
      run_txn(0, 0, -1, 32'h0000_0013);

      // Simultaneous store and fetch: data first, fetch next
      d_pend = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
      if_pend = 1'b1; if_addr = 32'h8000_0004;
      run_txn(0, 0, -1, 32'h5555_AAAA);
      chk32("prio_first", 32'(dut_win), 32'd1);
      run_txn(0, 1, -1, 32'h0000_0093);
      chk32("prio_second", 32'(dut_win), 32'd2);

      // Flush during WAIT_I squashes the response; next fetch is normal
      if_pend = 1'b1; if_addr = 32'h8000_0040;
      run_txn(0, 3, 1, 32'hCAFE_0001);
      if_pend = 1'b1; if_addr = 32'h8000_0044;
      run_txn(0, 0, -1, 32'hCAFE_0002);

      // Grant withheld for 5 cycles
      d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0A00; d_wdata = 32'h1234_5678; d_be = 4'hF;
      run_txn(5, 1, -1, 32'h0BAD_F00D);

      // Reset while waiting on a load; a late response must be dropped
      d_pend = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = '0; d_be = 4'hF;
      @(negedge clk); set_in(1'b0, 1'b0, '0, 1'b0); #1;
      chk1("rw_d_ack", bus.o_d_ack, 1'b1);
      d_pend = 1'b0;
      @(negedge clk); set_in(1'b1, 1'b0, '0, 1'b0); #1;
      chk32("rw_mem_addr", bus.o_mem_addr, 32'h200);
      @(negedge clk); set_in(1'b0, 1'b0, '0, 1'b0); rst = 1'b1; #1;
      chk1("rw_d_valid_in_rst", bus.o_d_valid, 1'b0);
      @(negedge clk); rst = 1'b0; set_in(1'b0, 1'b1, 32'h7777_7777, 1'b0); #1;
      chk1("rw_d_valid", bus.o_d_valid, 1'b0);
      chk32("rw_d_rdata", bus.o_d_rdata, 32'h0);
      chk1("rw_mem_req", bus.o_mem_req, 1'b0);
      chk32("rw_mem_be", 32'(bus.o_mem_be), 32'h0);
      chk1("rw_if_valid", bus.o_if_valid, 1'b0);
      starve = 0;
      if_pend = 1'b1; if_addr = 32'h8000_0100;
      run_txn(0, 0, -1, 32'h0000_0513);

`ifdef AUKV_ARB_FAIRNESS_EN
      // Continuous competition: fetch wins every third slot with LIMIT=2
      for (int i = 0; i < 6; i++) begin
         if (!d_pend) new_d();
         if (!if_pend) begin if_pend = 1'b1; if_addr = $urandom; end
         run_txn(0, 0, -1, $urandom);
         chk32("fair_order", 32'(dut_win), 32'(exp_order[i]));
      end
`else
      // Continuous competition: data always wins
      for (int i = 0; i < 3; i++) begin
         if (!d_pend) new_d();
         if (!if_pend) begin if_pend = 1'b1; if_addr = $urandom; end
         run_txn(0, 0, -1, $urandom);
         chk32("strict_order", 32'(dut_win), 32'(exp_order[0]));
      end
`endif

      // Randomized traffic
      for (int n = 0; n < 300; n++) begin
         int g, r, f;
         if (!d_pend && $urandom_range(0, 2) == 0) new_d();
         if (!if_pend && $urandom_range(0, 1) == 0) begin
            if_pend = 1'b1; if_addr = $urandom;
         end
         g = int'($urandom_range(0, 3));
         r = int'($urandom_range(0, 3));
         f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32'(g + r + 1))) : -1;
         run_txn(g, r, f, $urandom);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
